// File: rtl/arbiter_seq.sv
// arbiter_seq: byte-stream micro-sequencer feeding the bus arbiter.
// Accepts one instruction byte per valid/ready transfer. Loads take a
// following operand byte into reg_0 or reg_3. Routes drive arbiter_order
// and hold arbiter_sel high for field+1 cycles.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   inst_in          instruction/operand byte
//   inst_valid       inst_in valid
//   inst_ready       sequencer can accept inst_in (from state only)
//   reg_0, reg_3     source registers to arbiter
//   arbiter_order    arbiter source select
//   arbiter_sel      arbiter output enable
//   route_done       high on the final cycle of a route hold
//   busy             high whenever not idle
module arbiter_seq #(
  parameter int unsigned DW     = 8,
  parameter int unsigned HOLD_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    inst_in,
  input  logic          inst_valid,
  output logic          inst_ready,
  output logic [DW-1:0] reg_0,
  output logic [DW-1:0] reg_3,
  output logic [2:0]    arbiter_order,
  output logic          arbiter_sel,
  output logic          route_done,
  output logic          busy
);

  localparam logic [1:0] OP_LOAD0 = 2'b00;
  localparam logic [1:0] OP_LOAD3 = 2'b01;
  localparam logic [1:0] OP_ROUTE = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_ROUTE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       reg_0_q, reg_0_d;
  logic [DW-1:0]       reg_3_q, reg_3_d;
  logic [2:0]          order_q, order_d;
  logic                sel_q, sel_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic                tgt_q, tgt_d;   // 0: reg_0, 1: reg_3
  logic                xfer;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      reg_0_q <= '0;
      reg_3_q <= '0;
      order_q <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_0_q <= reg_0_d;
      reg_3_q <= reg_3_d;
      order_q <= order_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Ready depends on state alone so the producer never sees a comb path from valid
  assign inst_ready = (state_q == ST_IDLE) || (state_q == ST_OPERAND);
  assign xfer       = inst_valid & inst_ready;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    reg_0_d = reg_0_q;
    reg_3_d = reg_3_q;
    order_d = order_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          case (inst_in[7:6])
            OP_LOAD0: begin
              state_d = ST_OPERAND;
              tgt_d   = 1'b0;
            end
            OP_LOAD3: begin
              state_d = ST_OPERAND;
              tgt_d   = 1'b1;
            end
            OP_ROUTE: begin
              state_d = ST_ROUTE;
              order_d = inst_in[2:0];
              sel_d   = 1'b1;
              cnt_d   = HOLD_W'(inst_in[5:3]);
            end
            OP_NOP: begin
              sel_d = 1'b0;
            end
          endcase
        end
      end
      ST_OPERAND: begin
        // Operand byte is taken whole; its top bits are not an opcode here
        if (xfer) begin
          if (tgt_q) reg_3_d = DW'(inst_in);
          else       reg_0_d = DW'(inst_in);
          state_d = ST_IDLE;
        end
      end
      ST_ROUTE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else begin
          sel_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
      end
    endcase
  end

  assign reg_0         = reg_0_q;
  assign reg_3         = reg_3_q;
  assign arbiter_order = order_q;
  assign arbiter_sel   = sel_q;
  assign route_done    = (state_q == ST_ROUTE) && (cnt_q == '0);
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arbiter_seq.sv
// tb_arbiter_seq: directed-vector bench for arbiter_seq.
module tb_arbiter_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inst_in;
  logic       inst_valid;
  logic       inst_ready;
  logic [7:0] reg_0;
  logic [7:0] reg_3;
  logic [2:0] arbiter_order;
  logic       arbiter_sel;
  logic       route_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  arbiter_seq #(.DW(8), .HOLD_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_in       (inst_in),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .reg_0         (reg_0),
    .reg_3         (reg_3),
    .arbiter_order (arbiter_order),
    .arbiter_sel   (arbiter_sel),
    .route_done    (route_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer in a cycle where inst_ready is expected high
  task automatic send(input logic [7:0] b);
    inst_in    = b;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    inst_in    = 8'h00;
    inst_valid = 1'b0;

    // Reset
    step();
    step();
    check("rst_reg0",  32'(reg_0), 32'h00);
    check("rst_reg3",  32'(reg_3), 32'h00);
    check("rst_order", 32'(arbiter_order), 32'h0);
    check("rst_sel",   32'(arbiter_sel), 32'h0);
    check("rst_done",  32'(route_done), 32'h0);
    check("rst_ready", 32'(inst_ready), 32'h1);
    check("rst_busy",  32'(busy), 32'h0);
    rst = 1'b0;
    step();

    // Loads: the 0xF0 operand must not be decoded as a NOP opcode
    send(8'h00);
    check("ld0_busy",  32'(busy), 32'h1);
    check("ld0_ready", 32'(inst_ready), 32'h1);
    check("ld0_sel",   32'(arbiter_sel), 32'h0);
    send(8'hF0);
    check("ld0_reg0",  32'(reg_0), 32'hF0);
    check("ld0_idle",  32'(busy), 32'h0);
    send(8'h40);
    check("ld3_sel",   32'(arbiter_sel), 32'h0);
    send(8'h01);
    check("ld3_reg3",  32'(reg_3), 32'h01);
    check("ld3_reg0",  32'(reg_0), 32'hF0);
    check("ld3_sel",   32'(arbiter_sel), 32'h0);

    // Route 0x91: order 1, field 2 -> three sel cycles
    send(8'h91);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rt_sel%0d", i),   32'(arbiter_sel), 32'h1);
      check($sformatf("rt_ord%0d", i),   32'(arbiter_order), 32'h1);
      check($sformatf("rt_rdy%0d", i),   32'(inst_ready), 32'h0);
      check($sformatf("rt_done%0d", i),  32'(route_done), (i == 2) ? 32'h1 : 32'h0);
      step();
    end
    check("rt_end_sel",  32'(arbiter_sel), 32'h0);
    check("rt_end_busy", 32'(busy), 32'h0);
    check("rt_end_ord",  32'(arbiter_order), 32'h1);
    check("rt_reg0",     32'(reg_0), 32'hF0);
    check("rt_reg3",     32'(reg_3), 32'h01);

    // Back-pressure: 0x80 held valid during route 0xB8 (order 0, field 7)
    send(8'hB8);
    inst_in    = 8'h80;
    inst_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_sel%0d", i),  32'(arbiter_sel), 32'h1);
      check($sformatf("bp_rdy%0d", i),  32'(inst_ready), 32'h0);
      check($sformatf("bp_done%0d", i), 32'(route_done), (i == 7) ? 32'h1 : 32'h0);
      step();
    end
    check("bp_gap_sel",   32'(arbiter_sel), 32'h0);
    check("bp_gap_ready", 32'(inst_ready), 32'h1);
    check("bp_gap_busy",  32'(busy), 32'h0);
    step();
    inst_valid = 1'b0;
    check("bp2_sel",  32'(arbiter_sel), 32'h1);
    check("bp2_ord",  32'(arbiter_order), 32'h0);
    check("bp2_done", 32'(route_done), 32'h1);
    step();
    check("bp2_end_sel",  32'(arbiter_sel), 32'h0);
    check("bp2_end_busy", 32'(busy), 32'h0);

    // NOP after a route with order 6 (field 0)
    send(8'h86);
    check("nop_rt_sel", 32'(arbiter_sel), 32'h1);
    check("nop_rt_ord", 32'(arbiter_order), 32'h6);
    step();
    send(8'hC0);
    check("nop_sel",  32'(arbiter_sel), 32'h0);
    check("nop_ord",  32'(arbiter_order), 32'h6);
    check("nop_busy", 32'(busy), 32'h0);

    // Reset during OPERAND drops the pending load
    send(8'h00);
    check("rop_busy", 32'(busy), 32'h1);
    inst_in    = 8'h55;
    inst_valid = 1'b1;
    rst        = 1'b1;
    step();
    rst        = 1'b0;
    inst_valid = 1'b0;
    check("rop_reg0",  32'(reg_0), 32'h00);
    check("rop_busy2", 32'(busy), 32'h0);
    check("rop_ready", 32'(inst_ready), 32'h1);
    step();
    step();
    check("rop_reg0b", 32'(reg_0), 32'h00);
    check("rop_reg3b", 32'(reg_3), 32'h00);

    // Reset during route 0xBF (order 7, field 7)
    send(8'hBF);
    check("rrt_sel", 32'(arbiter_sel), 32'h1);
    check("rrt_ord", 32'(arbiter_order), 32'h7);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rrt_sel0",  32'(arbiter_sel), 32'h0);
    check("rrt_busy",  32'(busy), 32'h0);
    check("rrt_ready", 32'(inst_ready), 32'h1);
    check("rrt_done",  32'(route_done), 32'h0);
    check("rrt_ord0",  32'(arbiter_order), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
